// File: rtl/downscale_block_16.sv
// binary32 -> binary16 streaming converter, round-to-nearest-even, one registered stage.
// Optional: define DOWNSCALE_SATURATE_EN to clamp finite overflow to +/-max finite instead of +/-inf.
module downscale_block_16 #(
  parameter int data_size      = 16,
  parameter int number_of_data = 10
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic                          downscale_data_valid_i,
  input  logic signed [2*data_size-1:0] downscale_data_i,
  output logic                          downscale_data_valid_o,
  output logic        [data_size-1:0]   downscale_data_o
);

  if (data_size != 16 || number_of_data < 1) begin : g_bad_cfg
    $error("downscale_block_16: only data_size=16 and number_of_data>=1 are supported");
  end

`ifdef DOWNSCALE_SATURATE_EN
  localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
  localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

  logic               sgn;
  logic [7:0]         e32;
  logic [22:0]        frac;
  logic signed [9:0]  e16;
  logic               rnd_n;
  logic [14:0]        norm_sum;
  logic [4:0]         sub_k;
  logic [33:0]        sub_ext;
  logic               rnd_s;
  logic [14:0]        sub_sum;
  logic [15:0]        result;

  always_comb begin
    sgn  = downscale_data_i[31];
    e32  = downscale_data_i[30:23];
    frac = downscale_data_i[22:0];
    e16  = $signed({2'b00, e32}) - 10'sd112;

    // exponent and mantissa concatenated so a rounding carry bumps the exponent
    rnd_n    = frac[12] & ((|frac[11:0]) | frac[13]);
    norm_sum = {e16[4:0], frac[22:13]} + {14'd0, rnd_n};

    // below e16 = -11 the guard bit is already above the significand, result is zero
    sub_k   = (e16 < -10'sd11) ? 5'd11 : 5'(-e16);
    sub_ext = {1'b1, frac, 10'd0} >> sub_k;
    rnd_s   = sub_ext[23] & ((|sub_ext[22:0]) | sub_ext[24]);
    sub_sum = {5'd0, sub_ext[33:24]} + {14'd0, rnd_s};

    if (e32 == 8'hFF) begin
      result = (frac != 23'd0) ? {sgn, 15'h7E00} : {sgn, 15'h7C00};
    end else if (e32 == 8'h00) begin
      result = {sgn, 15'h0000};
    end else if (e16 > 10'sd30) begin
      result = {sgn, OVF_MAG};
    end else if (e16 >= 10'sd1) begin
      result = (norm_sum[14:10] == 5'h1F) ? {sgn, OVF_MAG} : {sgn, norm_sum};
    end else begin
      result = {sgn, sub_sum};
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      downscale_data_valid_o <= 1'b0;
      downscale_data_o       <= '0;
    end else begin
      downscale_data_valid_o <= downscale_data_valid_i;
      if (downscale_data_valid_i) begin
        downscale_data_o <= result;
      end
    end
  end

endmodule

// File: tb/tb_downscale_block_16.sv
// Directed and randomized check of downscale_block_16 against an independent float-to-half model.
module tb_downscale_block_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vi;
  logic [31:0] di;
  logic        vo;
  logic [15:0] dout;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_exp;

`ifdef DOWNSCALE_SATURATE_EN
  localparam logic [14:0] OVF_H = 15'h7BFF;
`else
  localparam logic [14:0] OVF_H = 15'h7C00;
`endif

  downscale_block_16 #(.data_size(16), .number_of_data(10)) dut (
    .clock_i                (clk),
    .reset_n_i              (rst_n),
    .downscale_data_valid_i (vi),
    .downscale_data_i       (di),
    .downscale_data_valid_o (vo),
    .downscale_data_o       (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // value = sig * 2^(E-23); quantize to the half ulp grid with RNE
  function automatic logic [15:0] half_ref(input logic [31:0] x);
    logic   s;
    int     e, big_e, sh, bits;
    longint sig, n, rem, half;
    s = x[31];
    e = int'(x[30:23]);
    if (e == 255) return (x[22:0] != 0) ? {s, 15'h7E00} : {s, 15'h7C00};
    if (e == 0) return {s, 15'h0000};
    sig   = longint'({1'b1, x[22:0]});
    big_e = e - 127;
    if (big_e > 15) return {s, OVF_H};
    sh = (big_e >= -14) ? 13 : (-1 - big_e);
    if (sh > 40) sh = 40;
    n    = sig >> sh;
    rem  = sig - (n << sh);
    half = 64'sd1 << (sh - 1);
    if (rem > half || (rem == half && n[0])) n++;
    if (big_e >= -14) bits = ((big_e + 15) << 10) + int'(n) - 1024;
    else bits = int'(n);
    if (bits >= 32'h7C00) return {s, OVF_H};
    return {s, bits[14:0]};
  endfunction

  task automatic pulse(input string tag, input logic [31:0] x, input logic [15:0] exp);
    @(negedge clk);
    vi = 1'b1;
    di = x;
    @(negedge clk);
    chk({tag, "_d"}, 32'(dout), 32'(exp));
    chk({tag, "_v"}, 32'(vo), 32'd1);
    vi = 1'b0;
    di = $urandom;
    @(negedge clk);
    chk({tag, "_v0"}, 32'(vo), 32'd0);
    chk({tag, "_hold"}, 32'(dout), 32'(exp));
    last_exp = exp;
  endtask

  initial begin
    logic [31:0] s_in [4]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h80000000};
    logic [15:0] s_out [4] = '{16'h3C00, 16'hBC00, 16'h0000, 16'h8000};
    logic        pv;
    logic [15:0] pexp;
    int          n_in, n_out;

    rst_n = 1'b0;
    vi    = 1'b1;
    di    = 32'h3F800000;
    #12;
    chk("rst_v", 32'(vo), 32'd0);
    chk("rst_d", 32'(dout), 32'd0);
    #16;
    chk("rst_v2", 32'(vo), 32'd0);
    chk("rst_d2", 32'(dout), 32'd0);
    #2;
    vi    = 1'b0;
    rst_n = 1'b1;

    pulse("p0", 32'hC05060D2, 16'hC283);
    pulse("p1", 32'h40A5D0A4, 16'h452F);
    pulse("p2", 32'hBE3BD70A, 16'hB1DF);
    pulse("p3", 32'h3F9DF3B6, 16'h3CF0);

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vi = 1'b1;
      di = s_in[i];
      @(negedge clk);
      chk($sformatf("b2b%0d_v", i), 32'(vo), 32'd1);
      chk($sformatf("b2b%0d_d", i), 32'(dout), 32'(s_out[i]));
    end
    vi = 1'b0;

    pulse("min_norm", 32'h38800000, 16'h0400);
    pulse("min_sub", 32'h33800000, 16'h0001);
    pulse("tie_zero", 32'h33000000, 16'h0000);
    pulse("f32_sub", 32'h00000001, 16'h0000);
`ifdef DOWNSCALE_SATURATE_EN
    pulse("rnd_ovf", 32'h477FF000, 16'h7BFF);
`else
    pulse("rnd_ovf", 32'h477FF000, 16'h7C00);
`endif
    pulse("max_fin", 32'h477FE000, 16'h7BFF);
    pulse("neg_inf", 32'hFF800000, 16'hFC00);
    pulse("nan", 32'h7FC00001, 16'h7E00);
    pulse("neg_tiny", 32'hB3C00000, 16'h8002);

    // asynchronous reset with a result in flight
    @(negedge clk);
    vi = 1'b1;
    di = 32'h3F800000;
    @(posedge clk);
    #2;
    chk("mid_v_pre", 32'(vo), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_v", 32'(vo), 32'd0);
    chk("mid_d", 32'(dout), 32'd0);
    @(negedge clk);
    vi    = 1'b0;
    rst_n = 1'b1;
    pulse("post_rst", 32'h40000000, 16'h4000);

    pv = 1'b0;
    pexp = 16'h0000;
    n_in = 0;
    n_out = 0;
    for (int i = 0; i <= 10000; i++) begin
      @(negedge clk);
      chk("rnd_v", 32'(vo), 32'(pv));
      if (vo) n_out++;
      if (pv) begin
        chk("rnd_d", 32'(dout), 32'(pexp));
        last_exp = pexp;
      end else begin
        chk("rnd_hold", 32'(dout), 32'(last_exp));
      end
      if (i == 10000) begin
        vi = 1'b0;
      end else begin
        vi = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: di = $urandom;
          1: di = {1'($urandom), 8'($urandom_range(95, 145)), 23'($urandom)};
          2: di = {1'($urandom), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                   ($urandom_range(0, 1) != 0) ? 23'd0 : 23'($urandom)};
          default: di = {1'($urandom),
                         ($urandom_range(0, 1) != 0) ? 8'($urandom_range(100, 115))
                                                     : 8'($urandom_range(140, 143)),
                         23'($urandom)};
        endcase
        if (vi) n_in++;
      end
      pv   = vi;
      pexp = half_ref(di);
    end
    chk("pulse_count", 32'(n_out), 32'(n_in));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
